// File: rtl/alu_multicycle.sv
// EX-stage execution unit: the single-cycle ALU ops finish one cycle after start.
// MUL is an iterative shift-add over WIDTH cycles and holds busy_o high while it runs.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [4:0]       shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             illegal_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRAV = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic [CW-1:0]    r_cnt;
    logic             r_zero;
    logic             r_done;
    logic             r_illegal;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_illegal;
    logic [WIDTH-1:0] w_prod_next;
    logic             w_is_mul;
    logic             w_last_iter;

    assign w_is_mul    = (ctrl_i == OP_MUL);
    assign w_last_iter = (r_cnt == '0);
    // The final partial-product add happens on the same edge that publishes the result.
    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

    always_comb begin
        w_alu_res = '0;
        w_illegal = 1'b0;
        case (ctrl_i)
            OP_AND:  w_alu_res = src1_i & src2_i;
            OP_OR:   w_alu_res = src1_i | src2_i;
            OP_ADD:  w_alu_res = src1_i + src2_i;
            OP_SUB:  w_alu_res = src1_i - src2_i;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SRA:  w_alu_res = $signed(src2_i) >>> shamt_i;
            OP_SRAV: w_alu_res = $signed(src2_i) >>> src1_i[4:0];
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i && w_is_mul) w_state_next = S_MUL;
            S_MUL:   if (w_last_iter) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_is_mul) begin
                            r_mcand  <= src1_i;
                            r_mplier <= src2_i;
                            r_prod   <= '0;
                            r_cnt    <= CW'(WIDTH - 1);
                        end else begin
                            r_result  <= w_alu_res;
                            r_zero    <= (w_alu_res == '0);
                            r_illegal <= w_illegal;
                            r_done    <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (w_last_iter) begin
                        r_result  <= w_prod_next;
                        r_zero    <= (w_prod_next == '0);
                        r_illegal <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o  = r_result;
    assign zero_o    = r_zero;
    assign busy_o    = (r_state == S_MUL);
    assign done_o    = r_done;
    assign illegal_o = r_illegal;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares whenever done_o is presented.
module tb_alu_multicycle;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  ctrl_i = 4'b0000;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [4:0]  shamt_i = '0;
    logic [31:0] result_o;
    logic        zero_o;
    logic        busy_o;
    logic        done_o;
    logic        illegal_o;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   txn = 0;
    logic last_done;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .shamt_i  (shamt_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: one line per completed transaction.
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done_o=1 result=%h, expected no done", result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                txn++;
                check("result", result_o, e.res);
                check("zero", {31'b0, zero_o}, {31'b0, e.zero});
                check("illegal", {31'b0, illegal_o}, {31'b0, e.ill});
                $display("txn %0d: result=%h zero=%0b illegal=%0b (expected %h %0b %0b)",
                         txn, result_o, zero_o, illegal_o, e.res, e.zero, e.ill);
            end
        end
    end

    task automatic push(input logic [31:0] r, input logic ill);
        exp_t e;
        e.res  = r;
        e.zero = (r == 32'h0);
        e.ill  = ill;
        exp_q.push_back(e);
    endtask

    // Drives a start at the next negedge; last_done captures done_o at that negedge.
    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(negedge clk_i);
        last_done = done_o;
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        shamt_i = sh;
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        last_done = done_o;
        start_i = 1'b0;
    endtask

    // Runs a MUL from issue to done; optionally disturbs inputs mid-flight.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                           input logic disturb, input string name);
        int busy_cnt = 0;
        int done_at = 0;
        push(p, 1'b0);
        drive(4'b1011, a, b, 5'd0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (disturb && (i == 5 || i == 6)) begin
                start_i = 1'b1;
                ctrl_i  = (i == 5) ? 4'b0010 : 4'b1011;
                src1_i  = 32'hDEAD_BEEF;
                src2_i  = 32'h1234_5678;
            end
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_at = i;
                break;
            end
        end
        check({name, "_done_latency"}, done_at, 33);
        check({name, "_busy_cycles"}, busy_cnt, 32);
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk_i);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_result", result_o, 32'h0);
        check("rst_zero", {31'b0, zero_o}, 32'd1);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_illegal", {31'b0, illegal_o}, 32'd0);
        rst_i = 1'b0;
        repeat (5) idle_cycle();
        check("idle_no_done", {31'b0, done_o}, 32'd0);

        // ADD overflow wrap, SUB to zero, signed SLT
        push(32'h8000_0000, 1'b0); drive(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
        idle_cycle();
        check("add_done_latency", {31'b0, last_done}, 32'd1);
        push(32'h0, 1'b0);         drive(4'b0110, 32'd5, 32'd5, 5'd0);
        idle_cycle();
        push(32'h1, 1'b0);         drive(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);
        idle_cycle();
        idle_cycle();

        // Back-to-back single-cycle ops
        push(32'h7, 1'b0);         drive(4'b0010, 32'd3, 32'd4, 5'd0);
        push(32'hF000_F000, 1'b0); drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("b2b_done1", {31'b0, last_done}, 32'd1);
        push(32'h0F0F_00F0, 1'b0); drive(4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
        check("b2b_done2", {31'b0, last_done}, 32'd1);
        idle_cycle();
        check("b2b_done3", {31'b0, last_done}, 32'd1);
        idle_cycle();

        // Arithmetic shifts
        push(32'hF800_0000, 1'b0); drive(4'b1000, 32'h0, 32'h8000_0000, 5'd4);
        push(32'hF800_0001, 1'b0); drive(4'b1001, 32'h24, 32'h8000_0010, 5'd0);
        idle_cycle();
        idle_cycle();

        // Multiplication
        run_mul(32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0, "mul1");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul2");
        run_mul(32'd3, 32'd5, 32'd15, 1'b1, "mul_disturb");
        idle_cycle();

        // Illegal code, then ADD clears illegal
        push(32'h0, 1'b1);         drive(4'b0101, 32'h1234, 32'h5678, 5'd0);
        push(32'h2, 1'b0);         drive(4'b0010, 32'd1, 32'd1, 5'd0);
        idle_cycle();
        idle_cycle();

        // Reset in the middle of a MUL
        drive(4'b1011, 32'h1111_1111, 32'h0000_0003, 5'd0);
        for (int i = 0; i < 10; i++) idle_cycle();
        check("pre_abort_busy", {31'b0, busy_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy_o}, 32'd0);
        check("abort_done", {31'b0, done_o}, 32'd0);
        check("abort_result", result_o, 32'h0);
        check("abort_zero", {31'b0, zero_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 35; i++) begin
            idle_cycle();
            if (done_o) begin
                total++;
                bad++;
                $display("FAIL abort_no_done: got done_o=1 at cycle %0d, expected 0", i);
            end
        end
        run_mul(32'd7, 32'd6, 32'h2A, 1'b0, "mul_after_abort");

        repeat (3) idle_cycle();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execution unit that consumes the 4-bit ALU control code from the ALU controller and performs the selected operation on two 32-bit operands.
- Logic, add/sub, compare and shift ops complete in one cycle; MUL runs as an iterative shift-add multiplier over WIDTH cycles.
- A start/busy/done handshake lets the pipeline stall during multiplication.
- Sits in the EX stage between the register-file/immediate muxes and the EX/MEM pipeline register.

Parameters:
- WIDTH, 32, operand and result width in bits; MUL iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request to execute; sampled only while busy_o=0
- ctrl_i  input  4  ALU control code
- src1_i  input  WIDTH  operand A (rs)
- src2_i  input  WIDTH  operand B (rt or immediate)
- shamt_i  input  5  shift amount for SRA
- result_o  output  WIDTH  registered result; held until next done_o
- zero_o  output  1  registered, 1 when the result written at done is all zeros
- busy_o  output  1  1 while a MUL is in progress
- done_o  output  1  one-cycle pulse when result_o/zero_o update
- illegal_o  output  1  registered, set with done_o when ctrl_i was unsupported

Behaviour:
- Reset (async, rst_i=1): state=IDLE; result_o=0, zero_o=1, busy_o=0, done_o=0, illegal_o=0; iteration counter and partial product cleared.
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wrap modulo 2^WIDTH, no overflow flag)
  - 0110 SUB (src1-src2, wrap)
  - 0111 SLT (signed compare; result = {0..0, src1<src2})
  - 1000 SRA (src2 >>> shamt_i)
  - 1001 SRAV (src2 >>> src1_i[4:0])
  - 1011 MUL (low WIDTH bits of src1*src2; identical for signed/unsigned)
  - All other codes: result_o=0, illegal_o=1, done_o pulses next cycle.
- States: IDLE, MUL.
- IDLE, start_i=1, non-MUL code sampled at edge k:
  - result_o, zero_o and illegal_o update at edge k.
  - done_o=1 for the cycle after edge k, then 0.
  - Latency 1; back-to-back starts every cycle are allowed.
- IDLE, start_i=1, ctrl_i=1011 at edge k:
  - Latch multiplicand and multiplier; clear product; counter=WIDTH-1.
  - busy_o=1 from edge k; go to MUL.
- MUL, each edge:
  - If multiplier LSB=1, product += multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; counter -= 1.
  - At the edge where counter=0 is consumed (edge k+WIDTH): result_o=product, zero_o updates, illegal_o=0, busy_o=0, done_o=1 for one cycle; return to IDLE.
  - MUL latency = WIDTH cycles.
- start_i while busy_o=1: ignored, no queueing; inputs may change freely during MUL because operands are latched.
- start_i in the same cycle that done_o is asserted is accepted, since state is IDLE.
- done_o never asserts without a preceding accepted start.
- result_o, zero_o and illegal_o change only at done.
- Reset mid-MUL: immediate abort to IDLE; no done_o; outputs take reset values.
- zero_o is computed from the full WIDTH-bit result being written.

Test Plan:
- Reset then idle: rst_i pulse -> result_o=0, zero_o=1, busy_o=0, done_o=0; no done_o while start_i=0.
- ADD/SUB/SLT: ADD 0x7FFFFFFF+1 -> 0x80000000, done_o one cycle later. SUB 5-5 -> 0, zero_o=1. SLT 0xFFFFFFFF vs 1 -> 1. Back-to-back starts -> done_o high on consecutive cycles.
- Shifts: SRA src2=0x80000000, shamt_i=4 -> 0xF8000000. SRAV src1=0x24 (uses 4), src2=0x80000010 -> 0xF8000001.
- MUL: 0x00012345*0x00000100 -> 0x01234500 with done_o exactly 32 cycles after start and busy_o high 32 cycles. 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. start_i pulsed and operands changed mid-MUL -> ignored, result unchanged.
- Illegal code 0101 -> result_o=0, illegal_o=1, done_o pulse. A following ADD clears illegal_o.
- Reset at cycle 10 of a MUL -> busy_o=0 immediately, no done_o; a new MUL afterwards completes correctly.
